// File: rtl/loader_pkg.sv
// Shared types and address remapping for the ROM download path into the
// dual-port sdram controller.
package loader_pkg;

  typedef enum logic {TGT_P1, TGT_P2} target_t;

  typedef struct packed {
    target_t     tgt;
    logic [24:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
  } sd_loc_t;

  // Byte address to word address plus byte lane.
  function automatic sd_loc_t remap_p1(input logic [23:0] addr);
    sd_loc_t r;
    r.a  = addr[23:1];
    r.ds = {addr[0], ~addr[0]};
    return r;
  endfunction

  // Offset bit 13 selects the byte lane, so two 8 KB byte planes of the
  // graphics region pack into one 16-bit word.
  function automatic sd_loc_t remap_p2(input logic [23:0] addr, input logic [23:0] base);
    logic [23:0] off;
    sd_loc_t     r;
    off  = addr - base;
    r.a  = {off[23:14], off[12:0]};
    r.ds = {off[13], ~off[13]};
    return r;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module loader_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rp];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Captures data_io download bytes, routes them to sdram port1 (CPU ROMs) or
// port2 (graphics), and serialises toggle req/ack writes through a FIFO.
module ioctl_sdram_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [24:0] BG_BASE    = 25'h00C000,
  parameter logic [24:0] BG_END     = 25'h014000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        busy,
  output logic        rom_loaded,
  output logic        overflow,
  output logic [24:0] bytes_written
);

  logic        wr_last, downl_last, done;
  logic        ev, in_p1, in_p2, downl_rise, downl_fall;
  logic        cap_vld;
  fifo_entry_t cap_entry, head;
  logic        fifo_full, fifo_empty, fifo_pop;
  state_t      state_q, state_d;
  target_t     cur_tgt;
  logic        ack_match, xfer_done;
  sd_loc_t     loc1, loc2;
  logic        head_msb_unused;

  assign ev         = ioctl_downl & ioctl_wr & ~wr_last & (ioctl_index == ROM_INDEX);
  assign in_p1      = (ioctl_addr < BG_BASE);
  assign in_p2      = ~in_p1 & (ioctl_addr < BG_END);
  assign downl_rise = ioctl_downl & ~downl_last;
  assign downl_fall = ~ioctl_downl & downl_last;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_last    <= 1'b0;
      downl_last <= 1'b0;
      cap_vld    <= 1'b0;
      cap_entry  <= '0;
    end else begin
      wr_last        <= ioctl_wr;
      downl_last     <= ioctl_downl;
      cap_vld        <= ev & (in_p1 | in_p2);
      cap_entry.tgt  <= in_p1 ? TGT_P1 : TGT_P2;
      cap_entry.addr <= ioctl_addr;
      cap_entry.data <= ioctl_dout;
    end
  end

  loader_fifo #(.DEPTH(FIFO_DEPTH), .T(fifo_entry_t)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (cap_vld),
    .push_data (cap_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Region bounds keep head.addr below 2^24, so bit 24 never reaches sdram.
  assign head_msb_unused = head.addr[24];
  assign loc1      = remap_p1(head.addr[23:0]);
  assign loc2      = remap_p2(head.addr[23:0], BG_BASE[23:0]);
  assign ack_match = (cur_tgt == TGT_P1) ? (port1_req == port1_ack)
                                         : (port2_req == port2_ack);

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    xfer_done = 1'b0;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = ISSUE;
      ISSUE: begin
        fifo_pop = 1'b1;
        state_d  = WAIT;
      end
      WAIT: if (ack_match) begin
        xfer_done = 1'b1;
        state_d   = fifo_empty ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_tgt   <= TGT_P1;
      port1_req <= port1_ack;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= port2_ack;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ISSUE) begin
        cur_tgt <= head.tgt;
        if (head.tgt == TGT_P1) begin
          port1_a   <= loc1.a;
          port1_ds  <= loc1.ds;
          port1_d   <= {2{head.data}};
          port1_req <= ~port1_req;
        end else begin
          port2_a   <= loc2.a;
          port2_ds  <= loc2.ds;
          port2_d   <= {2{head.data}};
          port2_req <= ~port2_req;
        end
      end
    end
  end

  // A byte still in the capture stage counts as pending for rom_loaded.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      done          <= 1'b0;
      rom_loaded    <= 1'b0;
      overflow      <= 1'b0;
      bytes_written <= '0;
    end else if (downl_rise) begin
      done          <= 1'b0;
      rom_loaded    <= 1'b0;
      overflow      <= 1'b0;
      bytes_written <= '0;
    end else begin
      if (downl_fall) done <= 1'b1;
      if (done && fifo_empty && !cap_vld && state_q == IDLE) rom_loaded <= 1'b1;
      if (cap_vld && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (xfer_done && !(&bytes_written)) bytes_written <= bytes_written + 25'd1;
    end
  end

  assign busy = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
- Sits between data_io and the dual-port sdram controller on the ROM download path.
- Edge-detects ioctl_wr bytes and routes each byte by address: main/sub CPU ROM region to sdram port1, background/sprite region to port2 (merged into 16-bit words).
- Buffers bytes in a small FIFO and issues toggle-style req/ack handshakes, waiting for each ack.
- Reports rom_loaded once the download has ended and every write has been acknowledged.

Parameters:
- ROM_INDEX, 8'd0: ioctl_index value accepted; bytes with any other index are ignored.
- BG_BASE, 25'h00C000: first byte address of the port2 region.
- BG_END, 25'h014000: first byte address after the port2 region (exclusive).
- FIFO_DEPTH, 4: pending-write entries; must be a power of two, ≥2.

Ports:
- clk_sys  in  1  system clock (48 MHz domain)
- reset  in  1  synchronous, active-high reset
- ioctl_downl  in  1  download active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  byte strobe (level; rising edge is the event)
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- port1_req  out  1  toggle request, port1
- port1_ack  in  1  toggle acknowledge, port1
- port1_a  out  23  word address, port1
- port1_ds  out  2  byte selects {hi,lo}, port1
- port1_d  out  16  write data, port1
- port2_req, port2_ack, port2_a, port2_ds, port2_d: same widths and meanings for port2
- busy  out  1  FIFO non-empty or handshake outstanding
- rom_loaded  out  1  sticky: download finished and drained
- overflow  out  1  sticky: byte dropped because the FIFO was full
- bytes_written  out  25  count of bytes acknowledged by sdram

Behaviour:
- Clock and reset: single clock clk_sys. reset is synchronous and active-high.
- Reset values:
  - port1_req <= port1_ack and port2_req <= port2_ack (no transaction pending).
  - a/ds/d outputs 0; FIFO empty; state IDLE.
  - busy 0, rom_loaded 0, overflow 0, bytes_written 0.
  - wr_last 0, downl_last 0.
- Capture:
  - Event = ioctl_downl & ioctl_wr & ~wr_last & (ioctl_index == ROM_INDEX).
  - If addr < BG_BASE, the entry targets port1.
  - Else if addr < BG_END, it targets port2.
  - Otherwise the byte is discarded: no push, counter unchanged.
  - Push {target, addr, dout} on the cycle after the event is sampled.
- Remap:
  - Port1: a = addr[23:1]; ds = {addr[0], ~addr[0]}.
  - Port2: off = addr − BG_BASE; a = {off[23:14], off[12:0]}; ds = {off[13], ~off[13]}.
  - d = {dout, dout} for both ports.
- FSM:
  - IDLE: if FIFO non-empty → ISSUE.
  - ISSUE: pop head; drive the target's a/ds/d; toggle the target's req → WAIT.
  - WAIT: when target req == target ack → bytes_written +1; go to ISSUE if FIFO non-empty, else IDLE.
- Handshake rules:
  - a/ds/d are held stable from the req toggle until ack matches.
  - At most one transaction is outstanding across both ports.
- Latency: with an empty FIFO in IDLE, req toggles 3 cycles after the cycle in which the edge is sampled (push, IDLE→ISSUE, ISSUE toggles).
- Full FIFO:
  - An event arriving when full sets overflow and drops the byte.
  - A push and a pop in the same cycle when full is legal: count unchanged, no overflow.
- Download end:
  - downl_last & ~ioctl_downl arms a done flag.
  - rom_loaded sets on the first cycle where done is armed, the FIFO is empty and the state is IDLE.
- Download restart: a rising edge of ioctl_downl clears rom_loaded, overflow and bytes_written. The FIFO and FSM are not disturbed.
- Reset mid-transaction: the transaction is abandoned, no further toggles are issued, and the FIFO is flushed.
- Pointer and counter wrap: FIFO pointers wrap modulo FIFO_DEPTH. bytes_written saturates at all-ones.
- busy = (state != IDLE) | FIFO non-empty.

Decomposition:
- Shared package loader_pkg:
  - typedef target_t (TGT_P1, TGT_P2).
  - typedef fifo_entry_t {target_t tgt; logic [24:0] addr; logic [7:0] data}.
  - typedef state_t (IDLE, ISSUE, WAIT).
  - The port2 remap function.
- One sub-module: loader_fifo, a synchronous FIFO with push/pop/full/empty and simultaneous push+pop when full. It is parameterised by depth and entry type.

Test Plan:
- Single byte, addr 25'h000003, data 8'hA5, ack returned 4 cycles after req → port1_a=23'h000001, ds=2'b10, d=16'hA5A5, port1_req toggles once, bytes_written=1.
- Port2 remap, addr 25'h00E001, data 8'h3C → off=25'h2001, port2_a=23'h000001, ds=2'b10, d=16'h3C3C, port1_req unchanged.
- Out-of-range addr 25'h014000 and index 8'd1 bytes → no req toggles, bytes_written stays 0.
- Burst of 6 bytes, one per 2 cycles, ack withheld 40 cycles → first FIFO_DEPTH+1 bytes kept (one outstanding + 4 queued), later bytes dropped, overflow=1, busy high until drained.
- Download ends with 3 entries pending → rom_loaded rises only on the cycle after the last ack match, then stays 1.
- Assert reset while WAIT with req≠ack → next cycle req equals ack, FIFO empty, busy=0, no further toggles after ack changes.
